// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin reservation allocator with wormhole-style hold
// Ports:
//   clk, rst                  - rising-edge clock, synchronous active-high reset
//   routeReserveRequestValid  - per input, request for a reservation
//   routeReserveRequest       - per input, requested output index (REQUEST_WIDTH bits each)
//   routeRelieve              - per input, owner releases its reservation
//   routeReserveStatus        - per input, 1 while it holds a reservation
//   out_busy, out_sel         - per output, reserved flag and owning input select
module switch_allocator #(
    parameter int INPUTS        = 4,
    parameter int OUTPUTS       = 4,
    parameter int REQUEST_WIDTH = 2,
    parameter int SEL_WIDTH     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS-1:0]            routeReserveRequestValid,
    input  logic [INPUTS*REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic [INPUTS-1:0]            routeRelieve,
    output logic [INPUTS-1:0]            routeReserveStatus,
    output logic [OUTPUTS-1:0]           out_busy,
    output logic [OUTPUTS*SEL_WIDTH-1:0] out_sel
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state [OUTPUTS];
    state_t state_n [OUTPUTS];
    logic [SEL_WIDTH-1:0] owner [OUTPUTS];
    logic [SEL_WIDTH-1:0] owner_n [OUTPUTS];
    logic [SEL_WIDTH-1:0] rr [OUTPUTS];
    logic [SEL_WIDTH-1:0] rr_n [OUTPUTS];
    logic done;
    int j;

    always_ff @(posedge clk) begin
        for (int o = 0; o < OUTPUTS; o++) begin
            if (rst) begin
                state[o] <= IDLE;
                owner[o] <= '0;
                rr[o]    <= '0;
            end else begin
                state[o] <= state_n[o];
                owner[o] <= owner_n[o];
                rr[o]    <= rr_n[o];
            end
        end
    end

    // Status is derived from the per-output owners so it can never disagree with out_busy/out_sel.
    always_comb begin
        routeReserveStatus = '0;
        for (int o = 0; o < OUTPUTS; o++)
            if (state[o] == BUSY) routeReserveStatus[owner[o]] = 1'b1;
    end

    always_comb begin
        done = 1'b0;
        j    = 0;
        for (int o = 0; o < OUTPUTS; o++) begin
            state_n[o] = state[o];
            owner_n[o] = owner[o];
            rr_n[o]    = rr[o];
            done       = 1'b0;
            if (state[o] == BUSY)
                state_n[o] = routeRelieve[owner[o]] ? IDLE : BUSY;
            else
                // Scan from the round-robin pointer; the first eligible input wins.
                for (int k = 0; k < INPUTS; k++) begin
                    j = (int'(rr[o]) + k) % INPUTS;
                    if (!done && routeReserveRequestValid[j] && !routeReserveStatus[j] &&
                        int'(routeReserveRequest[j*REQUEST_WIDTH +: REQUEST_WIDTH]) == o) begin
                        done       = 1'b1;
                        state_n[o] = BUSY;
                        owner_n[o] = SEL_WIDTH'(j);
                        rr_n[o]    = SEL_WIDTH'((j + 1) % INPUTS);
                    end
                end
        end
    end

    // out_sel keeps the last owner after release; it is only meaningful while busy.
    always_comb begin
        out_busy = '0;
        out_sel  = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            out_busy[o]                          = state[o] == BUSY;
            out_sel[o*SEL_WIDTH +: SEL_WIDTH]    = owner[o];
        end
    end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: scoreboard bench for switch_allocator (REQUEST_WIDTH=3 to reach out-of-range indices)
module tb_switch_allocator;
    localparam int RW = 3;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  valid = '0;
    logic [11:0] req = '0;
    logic [3:0]  relieve = '0;
    logic [3:0]  status;
    logic [3:0]  busy;
    logic [7:0]  sel;
    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] bz;
        logic [7:0] sl;
    } exp_t;
    exp_t sb[$];

    bit m_busy [4];
    int m_owner [4];
    int m_rr [4];

    switch_allocator #(.INPUTS(4), .OUTPUTS(4), .REQUEST_WIDTH(RW), .SEL_WIDTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .routeReserveRequestValid(valid),
        .routeReserveRequest(req),
        .routeRelieve(relieve),
        .routeReserveStatus(status),
        .out_busy(busy),
        .out_sel(sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pack(input int r0, input int r1, input int r2, input int r3);
        logic [11:0] p;
        p = {RW'(r3), RW'(r2), RW'(r1), RW'(r0)};
        return p;
    endfunction

    function automatic logic [3:0] m_status();
        logic [3:0] s;
        s = '0;
        for (int o = 0; o < 4; o++) if (m_busy[o]) s[m_owner[o]] = 1'b1;
        return s;
    endfunction

    // Advance the reference model with the driven inputs, push the expectation,
    // clock the DUT and compare against the popped expectation.
    task automatic step();
        logic [3:0] st;
        exp_t e;
        st = m_status();
        if (rst) begin
            for (int o = 0; o < 4; o++) begin
                m_busy[o] = 0; m_owner[o] = 0; m_rr[o] = 0;
            end
        end else begin
            for (int o = 0; o < 4; o++) begin
                if (m_busy[o]) begin
                    if (relieve[m_owner[o]]) m_busy[o] = 0;
                end else begin
                    int k = 0;
                    while (k < 4) begin
                        int i = (m_rr[o] + k) % 4;
                        if (valid[i] && !st[i] && int'(req[i*RW +: RW]) == o) begin
                            m_busy[o] = 1; m_owner[o] = i; m_rr[o] = (i + 1) % 4;
                            k = 4;
                        end
                        k++;
                    end
                end
            end
        end
        e.st = m_status();
        for (int o = 0; o < 4; o++) begin
            e.bz[o] = m_busy[o];
            e.sl[o*2 +: 2] = 2'(m_owner[o]);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("status", 32'(status), 32'(e.st));
        check("out_busy", 32'(busy), 32'(e.bz));
        check("out_sel", 32'(sel), 32'(e.sl));
    endtask

    task automatic quiet(input int n);
        valid = '0; relieve = '0; rst = 1'b0;
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = '0; relieve = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int g [5];
        int exp_g [5] = '{0, 1, 3, 0, 1};
        int n, h;
        bit prev;

        do_reset();
        check("reset_status", 32'(status), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_sel", 32'(sel), 0);

        // single request, relieve at cycle 5
        valid = 4'b0010; req = pack(0, 2, 0, 0);
        step();
        check("single_status", 32'(status), 32'h2);
        check("single_busy", 32'(busy), 32'h4);
        check("single_sel", 32'(sel[5:4]), 1);
        valid = '0;
        for (int c = 1; c < 5; c++) step();
        check("single_hold", 32'(status), 32'h2);
        relieve = 4'b0010;
        step();
        relieve = '0;
        check("single_release_status", 32'(status), 0);
        check("single_release_busy", 32'(busy), 0);

        // contention on output 0 from inputs 0, 1, 3
        do_reset();
        valid = 4'b1011; req = pack(0, 0, 0, 0);
        n = 0; h = 0; prev = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            h = m_busy[0] ? h + 1 : 0;
            relieve = '0;
            if (h == 2) relieve[m_owner[0]] = 1'b1;
            step();
            if (busy[0] && !prev) begin
                g[n] = int'(sel[1:0]);
                n++;
            end
            prev = busy[0];
        end
        check("grant_count", 32'(n), 5);
        for (int k = 0; k < 5; k++) check($sformatf("grant_order%0d", k), 32'(g[k]), 32'(exp_g[k]));
        quiet(4);

        // parallel grants
        do_reset();
        valid = 4'b1111; req = pack(3, 2, 1, 0);
        step();
        check("par_status", 32'(status), 32'hf);
        check("par_busy", 32'(busy), 32'hf);
        check("par_sel", 32'(sel), 32'h1b);
        valid = '0; relieve = 4'b1111;
        step();
        check("par_release", 32'(busy), 0);
        quiet(1);

        // ignored events
        valid = 4'b1000; req = pack(0, 0, 0, 5);
        for (int c = 0; c < 4; c++) step();
        check("oob_status", 32'(status), 0);
        valid = 4'b0001; req = pack(1, 0, 0, 0);
        step();
        check("own_status", 32'(status), 32'h1);
        valid = '0; relieve = 4'b0100;
        step();
        check("nonowner_relieve", 32'(busy), 32'h2);
        relieve = '0; valid = 4'b0001; req = pack(3, 0, 0, 0);
        step(); step();
        check("owner_rerequest_busy", 32'(busy), 32'h2);
        check("owner_rerequest_sel", 32'(sel[3:2]), 0);
        valid = '0; relieve = 4'b0001;
        step();
        quiet(1);

        // reset mid-operation
        valid = 4'b0110; req = pack(0, 2, 0, 0);
        step();
        check("pre_rst_busy", 32'(busy), 32'h5);
        rst = 1'b1; valid = 4'b1001; req = pack(0, 0, 0, 0);
        step();
        check("mid_rst_status", 32'(status), 0);
        check("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();
        check("post_rst_owner", 32'(sel[1:0]), 0);
        valid = '0; relieve = 4'b0001;
        step();
        quiet(1);

        // release and regrant on output 3
        valid = 4'b0010; req = pack(0, 3, 3, 0);
        step();
        valid = 4'b0100;
        step();
        check("regrant_wait", 32'(status), 32'h2);
        relieve = 4'b0010;
        step();
        relieve = '0;
        check("regrant_gap_busy", 32'(busy[3]), 0);
        step();
        check("regrant_status", 32'(status), 32'h4);
        check("regrant_sel", 32'(sel[7:6]), 2);
        quiet(1);

        // random traffic against the model
        for (int c = 0; c < 200; c++) begin
            rst = ($urandom_range(0, 40) == 0);
            valid = 4'($urandom);
            req = 12'($urandom);
            relieve = 4'($urandom) & 4'($urandom);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/switch_allocator.md
# switch_allocator

Output-reservation allocator for the router crossbar. Each input port asks for an output by index. The allocator grants each output to at most one input, using per-output round-robin fairness. A grant holds until the owning port relieves it, which gives wormhole-style packet locking. The block sits between the router's input ports and its switch, and drives the crossbar's per-output input selects.

## Interface
- `INPUTS`, 4, number of requesting input ports.
- `OUTPUTS`, 4, number of output ports.
- `REQUEST_WIDTH`, 2, width of each output-index request.
- `SEL_WIDTH`, 2, width of each per-output input select; 2^SEL_WIDTH >= INPUTS is required.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `routeReserveRequestValid`  in  INPUTS  input i requests a reservation.
- `routeReserveRequest`  in  INPUTS*REQUEST_WIDTH  requested output index, slice i*REQUEST_WIDTH.
- `routeRelieve`  in  INPUTS  owner releases its reservation (1-cycle pulse).
- `routeReserveStatus`  out  INPUTS  1 while input i holds a reservation.
- `out_busy`  out  OUTPUTS  1 while output o is reserved.
- `out_sel`  out  OUTPUTS*SEL_WIDTH  owning input of output o; valid only when `out_busy[o]`=1.

## Operation
- Per output o there is a 2-state FSM: IDLE and BUSY. Registered state per output:
  - owner index;
  - round-robin pointer `rr[o]` (SEL_WIDTH bits).
- Eligibility: input i is eligible for output o when all of the following hold:
  - `routeReserveRequestValid[i]`=1;
  - `routeReserveRequest[i]`==o;
  - `routeReserveStatus[i]`=0.
- IDLE -> BUSY: at least one eligible input exists.
  - The winner is the first eligible input scanning rr[o], rr[o]+1, …, wrapping mod INPUTS.
  - On the clock edge: owner<=winner, `rr[o]`<=(winner+1) mod INPUTS, `out_busy[o]`<=1, `out_sel[o]`<=winner, `routeReserveStatus[winner]`<=1.
- BUSY -> IDLE: `routeRelieve[owner]`=1.
  - On the clock edge: `out_busy[o]`<=0, `routeReserveStatus[owner]`<=0, `out_sel[o]` is held.
  - Arbitration does not happen in the release cycle.
- An input holds at most one reservation. Requests from an input whose status=1 are ignored.
- The per-output decisions are independent. Each input requests a single index, so no input can win two outputs in one cycle.
- Requests with an index >= OUTPUTS are never granted and have no side effect.
- `routeRelieve[i]` is ignored when input i holds no reservation. This includes a relieve pulse in the same cycle as its own grant decision: the grant still occurs.
- A request is sampled each cycle. If valid drops before a grant, nothing is remembered.
- The requester keeps valid high until it sees status=1. After the grant, valid is don't-care.
- Reset values:
  - all FSMs IDLE;
  - `routeReserveStatus`=0, `out_busy`=0, `out_sel`=0;
  - all rr=0, all owners=0.
- Reset mid-operation: every reservation is dropped on that edge, whatever the relieve and request inputs are. Reset overrides grants taken in the same cycle.

## Timing
- Grant latency: a request present at cycle t on an IDLE output produces status=1 at t+1. This is the registered output, with no combinational path from request to status.
- Release: relieve at cycle t gives status=0 and out_busy=0 at t+1. The earliest regrant of that output is visible at t+2.
- Back-to-back: an input that relieves at t may re-request at t+1 and compete normally. Round-robin ordering places it behind other waiters.
- Outputs depend only on registered state.

## Test plan
INPUTS=OUTPUTS=4, REQUEST_WIDTH=SEL_WIDTH=2 unless stated.
- Single request: input 1 requests output 2 at cycle 0, relieve at cycle 5 -> status[1]=1 and out_busy[2]=1 with out_sel[2]=1 over cycles 1–5; status[1]=0 and out_busy[2]=0 at cycle 6.
- Contention: after reset, inputs 0, 1 and 3 request output 0 continuously, and each owner relieves 2 cycles after its grant -> grant order 0, 1, 3, 0, 1. No input is granted twice while another waits.
- Parallel: inputs 0–3 request outputs 3, 2, 1, 0 at cycle 0 -> all four statuses and all four out_busy bits are 1 at cycle 1, with out_sel = {0, 1, 2, 3} for outputs {3, 2, 1, 0}.
- Ignored events: with REQUEST_WIDTH=3 and OUTPUTS=4, request index 5 -> no status ever. Relieve from non-owner input 2 while input 0 owns output 1 -> input 0's reservation is unchanged. An owner requesting again -> no change.
- Reset mid-operation: while outputs 0 and 2 are BUSY, assert rst for 1 cycle with new requests pending -> all status and out_busy bits are 0 the next cycle, rr=0, and requests are re-arbitrated from input 0 after deassert.
- Release/regrant: owner 1 of output 3 relieves at cycle t while input 2 waits -> out_busy[3]=0 at t+1, and status[2]=1 with out_sel[3]=2 at t+2.
